// File: rtl/fifo_ref_checker_pkg.sv
// Shared definitions for the FIFO reference checker: default geometry,
// mismatch_vec field positions, checker states and a saturating increment.
package fifo_ref_checker_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    localparam int MV_W           = 9;
    localparam int MV_DATA_OUT    = 8;
    localparam int MV_WR_ACK      = 7;
    localparam int MV_OVERFLOW    = 6;
    localparam int MV_UNDERFLOW   = 5;
    localparam int MV_FULL        = 4;
    localparam int MV_EMPTY       = 3;
    localparam int MV_ALMOSTFULL  = 2;
    localparam int MV_ALMOSTEMPTY = 1;
    localparam int MV_RESERVED    = 0;

    typedef logic [1:0] chk_state_t;
    localparam chk_state_t ST_IDLE  = 2'd0;
    localparam chk_state_t ST_CHECK = 2'd1;
    localparam chk_state_t ST_HALT  = 2'd2;

    localparam logic [31:0] NO_ERR_CYC = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ref_checker_if.sv
// Observed FIFO stimulus/response bundle; the monitor side drives it, the checker samples it.
interface fifo_ref_checker_if
    import fifo_ref_checker_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF
);
    logic             obs_rst_n;
    logic             obs_wr_en;
    logic             obs_rd_en;
    logic [WIDTH-1:0] obs_data_in;
    logic [WIDTH-1:0] obs_data_out;
    logic             obs_wr_ack;
    logic             obs_overflow;
    logic             obs_underflow;
    logic             obs_full;
    logic             obs_empty;
    logic             obs_almostfull;
    logic             obs_almostempty;

    modport master (
        output obs_rst_n, obs_wr_en, obs_rd_en, obs_data_in, obs_data_out,
               obs_wr_ack, obs_overflow, obs_underflow, obs_full, obs_empty,
               obs_almostfull, obs_almostempty
    );

    modport slave (
        input  obs_rst_n, obs_wr_en, obs_rd_en, obs_data_in, obs_data_out,
               obs_wr_ack, obs_overflow, obs_underflow, obs_full, obs_empty,
               obs_almostfull, obs_almostempty
    );
endinterface

// File: rtl/fifo_ref_checker_model.sv
// Cycle-accurate FIFO reference: updates on the same edge as the DUT so its
// outputs line up with the observed DUT outputs at zero latency.
module fifo_ref_model
    import fifo_ref_checker_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             obs_rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             wr_ack,
    output logic             overflow,
    output logic             underflow,
    output logic             full,
    output logic             empty,
    output logic             almostfull,
    output logic             almostempty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AFULL = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] data_out_reg;
    logic             wr_ack_reg, overflow_reg, underflow_reg;
    logic             wr_ok, rd_ok, advance;

    assign full        = (count_reg == CNT_FULL);
    assign almostfull  = (count_reg == CNT_AFULL);
    assign empty       = (count_reg == '0);
    assign almostempty = (count_reg == (AW+1)'(1));

    // full blocks the write and empty blocks the read, giving read-only / write-only when both fire
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign advance = ~freeze & obs_rst_n;

    always_ff @(posedge clk) begin
        if (!rst && advance && wr_ok) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (!freeze && !obs_rst_n)) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            wr_ack_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (advance) begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                data_out_reg <= mem[rd_ptr_reg];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            wr_ack_reg    <= wr_ok;
            overflow_reg  <= wr_en & full;
            underflow_reg <= rd_en & empty;
        end
    end

    assign data_out  = data_out_reg;
    assign wr_ack    = wr_ack_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: rtl/fifo_ref_checker.sv
// Golden-model checker: compares every observed FIFO output against the reference
// each CHECK cycle, keeps pass/fail statistics and optionally freezes on first error.
module fifo_ref_checker
    import fifo_ref_checker_pkg::*;
#(
    parameter int FIFO_WIDTH  = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    fifo_ref_checker_if.slave obs,
    output logic              mismatch,
    output logic [MV_W-1:0]   mismatch_vec,
    output logic [31:0]       err_count,
    output logic [31:0]       ok_count,
    output logic [31:0]       first_err_cyc,
    output logic              halted
);
    chk_state_t state_reg, state_next;
    logic            mismatch_reg;
    logic [MV_W-1:0] mismatch_vec_reg, diff_vec;
    logic [31:0]     err_count_reg, ok_count_reg, first_err_reg, cyc_idx_reg;

    logic [FIFO_WIDTH-1:0] m_data_out;
    logic m_wr_ack, m_overflow, m_underflow, m_full, m_empty, m_almostfull, m_almostempty;
    logic [6:0] model_flags, obs_flags;
    logic compare_valid, any_diff;

    fifo_ref_model #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_model (
        .clk         (clk),
        .rst         (rst),
        .freeze      (state_reg == ST_HALT),
        .obs_rst_n   (obs.obs_rst_n),
        .wr_en       (obs.obs_wr_en),
        .rd_en       (obs.obs_rd_en),
        .data_in     (obs.obs_data_in),
        .data_out    (m_data_out),
        .wr_ack      (m_wr_ack),
        .overflow    (m_overflow),
        .underflow   (m_underflow),
        .full        (m_full),
        .empty       (m_empty),
        .almostfull  (m_almostfull),
        .almostempty (m_almostempty)
    );

    // flag order matches mismatch_vec bits MV_WR_ACK down to MV_ALMOSTEMPTY
    assign model_flags = {m_wr_ack, m_overflow, m_underflow, m_full, m_empty,
                          m_almostfull, m_almostempty};
    assign obs_flags   = {obs.obs_wr_ack, obs.obs_overflow, obs.obs_underflow, obs.obs_full,
                          obs.obs_empty, obs.obs_almostfull, obs.obs_almostempty};

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_flag_cmp
            assign diff_vec[MV_ALMOSTEMPTY + gi] = model_flags[gi] ^ obs_flags[gi];
        end
    endgenerate
    assign diff_vec[MV_DATA_OUT] = (m_data_out != obs.obs_data_out);
    assign diff_vec[MV_RESERVED] = 1'b0;

    assign compare_valid = (state_reg == ST_CHECK) && obs.obs_rst_n;
    assign any_diff      = |diff_vec;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (en) state_next = ST_CHECK;
            ST_CHECK: begin
                if (compare_valid && any_diff && STOP_ON_ERR) state_next = ST_HALT;
                else if (!en)                                 state_next = ST_IDLE;
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            mismatch_reg     <= 1'b0;
            mismatch_vec_reg <= '0;
            err_count_reg    <= '0;
            ok_count_reg     <= '0;
            first_err_reg    <= NO_ERR_CYC;
            cyc_idx_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            mismatch_reg     <= compare_valid && any_diff;
            mismatch_vec_reg <= compare_valid ? diff_vec : '0;
            if (compare_valid) begin
                if (any_diff) begin
                    err_count_reg <= sat_inc(err_count_reg);
                    // err_count saturates and never wraps back, so zero means no error yet
                    if (err_count_reg == 32'd0) first_err_reg <= cyc_idx_reg;
                end else begin
                    ok_count_reg <= sat_inc(ok_count_reg);
                end
            end
            if (state_reg == ST_CHECK) cyc_idx_reg <= sat_inc(cyc_idx_reg);
        end
    end

    assign mismatch      = mismatch_reg;
    assign mismatch_vec  = mismatch_vec_reg;
    assign err_count     = err_count_reg;
    assign ok_count      = ok_count_reg;
    assign first_err_cyc = first_err_reg;
    assign halted        = (state_reg == ST_HALT);

endmodule

// File: doc/fifo_ref_checker.md
# fifo_ref_checker

Synthesizable golden-model checker that sits directly downstream of the FIFO DUT's monitored interface. It consumes the same stimulus and response signals that are sampled for coverage and scoring, runs a cycle-accurate reference model of the FIFO, and compares every DUT output each cycle. It accumulates pass/fail counts, flags the failing fields, and can freeze on the first error. This lets the check run in emulation/FPGA as well as in simulation.

## Interface
- FIFO_WIDTH, 16, data width
- FIFO_DEPTH, 8, entries; power of two, ≥4
- STOP_ON_ERR, 0, 1 = freeze counters and model on first mismatch
- clk  in  1  checker and DUT clock
- rst  in  1  checker reset; **one clock; reset is synchronous and active-high**
- en  in  1  checking enabled; checker leaves IDLE on first cycle with en=1
- obs_rst_n  in  1  DUT reset as driven to DUT (active-low); mirrored into model
- obs_wr_en, obs_rd_en  in  1 each  DUT stimulus
- obs_data_in  in  FIFO_WIDTH  DUT write data
- obs_data_out  in  FIFO_WIDTH  DUT read data
- obs_wr_ack, obs_overflow, obs_underflow, obs_full, obs_empty, obs_almostfull, obs_almostempty  in  1 each  DUT flags
- mismatch  out  1  registered pulse: any field disagreed last cycle
- mismatch_vec  out  9  per-field flags {data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, reserved=0}
- err_count, ok_count  out  32  compared cycles failed/passed
- first_err_cyc  out  32  cycle index of first mismatch; 0xFFFF_FFFF if none
- halted  out  1  STOP_ON_ERR freeze active

## Operation
- States: IDLE → CHECK (en=1) → HALT (mismatch and STOP_ON_ERR=1). CHECK → IDLE when en=0. HALT exits only on rst.
- Model, per clk edge: if obs_rst_n=0, clear count, pointers, wr_ack, overflow, underflow, and model data_out to 0. Otherwise:
  - wr_ok = wr_en & ~full; rd_ok = rd_en & ~empty.
  - Both enables when full: read only. Both when empty: write only.
  - wr_ack <= wr_ok; overflow <= wr_en & full; underflow <= rd_en & empty.
  - data_out <= mem[rd_ptr] on rd_ok, else hold.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is $clog2(DEPTH)+1 bits: +1 on wr_ok only, −1 on rd_ok only, unchanged on both.
- Model flags, combinational from count: full = (count==DEPTH); almostfull = (count==DEPTH−1); empty = (count==0); almostempty = (count==1).
- Compare runs in CHECK only, and only when obs_rst_n=1. Each field is compared against the model's current value. A compared cycle increments exactly one of ok_count or err_count.
- Counters saturate at 2^32−1. The cycle index counts CHECK cycles from 0.
- Model tracks the DUT in all states except HALT, where it is frozen.

## Timing
- Model registers update on the same edge as the DUT registers, so they are aligned at zero latency.
- mismatch, mismatch_vec, counters, and first_err_cyc are registered one cycle after the compared cycle.
- rst=1 at any time, including mid-HALT: state=IDLE, all model state=0, mismatch=0, mismatch_vec=0, counts=0, first_err_cyc=0xFFFF_FFFF, halted=0.
- obs_rst_n low mid-run clears the model on that edge. That cycle is not compared; counts are kept.

## Structure
- Shared package: FIFO_WIDTH/FIFO_DEPTH defaults, mismatch_vec bit-index constants, checker state enum.
- Sub-module fifo_ref_model: pointers, memory, count, and registered/combinational flags. Compare, counters, and FSM live in the top level.

## Test plan
- Reset then en=1 with 8 writes of 0x0001..0x0008 → full=1 after 8th, almostfull after 7th, ok_count=8 (plus idle cycles compared), err_count=0.
- Write while full (data 0xBEEF) → model overflow=1 next cycle, count stays 8; matching DUT → no mismatch.
- Read 8 from full, then one more → data_out 0x0001..0x0008 in order, then underflow=1; empty and almostempty correct; pointers wrap.
- Simultaneous wr+rd at count=3, at full, at empty → count 3/7/1 respectively; wr_ack 1/0/1.
- Force obs_data_out to differ by one bit on cycle 5 with STOP_ON_ERR=1 → mismatch=1 on cycle 6, mismatch_vec[data_out]=1, first_err_cyc=5, halted=1, counts frozen.
- Assert obs_rst_n mid-run at count=5 → model count=0, empty=1 next cycle, that cycle uncounted. Then rst=1 → all outputs return to their reset values.
